icache_resp_buffer: RTL and testbench
=====================================

ICACHE_RESP_BUFFER -- requirements
Module: icache_resp_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of 2, 2..16), entry count of both pending-tag and instruction queues.
REQ-002 SHALL have ports `clk`  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have port `resetn`  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports `req_fire`  in  1  ICache accepted a fetch this cycle (valid & addr_ok).
REQ-005 SHALL have port `req_vaddr`  in  32  virtual PC of accepted fetch.
REQ-006 SHALL have port `req_allow`  out  1  fetch unit may issue a request.
REQ-007 SHALL have port `resp_valid`  in  1  ICache data_ok.
REQ-008 SHALL have port `resp_inst`  in  32  returned instruction word.
REQ-009 SHALL have port `flush`  in  1  redirect (branch mispredict, exception, eret).
REQ-010 SHALL have ports `id_valid`  out  1, `id_ready`  in  1, `id_pc`  out  32, `id_inst`  out  32: decode handshake.

Function
REQ-011 SHALL push req_vaddr into pending-tag FIFO on req_fire; ICache responses return in request order.
REQ-012 SHALL, on resp_valid with discard count zero, pop pending head and push {pc, resp_inst} into instruction FIFO in the same edge.
REQ-013 SHALL present instruction FIFO head on id_pc/id_inst with id_valid = non-empty; pop on id_valid & id_ready.
REQ-014 SHALL drive req_allow = (pending count + instruction count) < DEPTH, guaranteeing every response has a slot.
REQ-015 SHALL treat req_fire while req_allow low as protocol error: ignored, no state change.
REQ-016 SHALL, on flush: empty instruction FIFO, load discard count with pending count (including a same-cycle req_fire), empty pending FIFO.
REQ-017 SHALL, while discard count > 0, drop each resp_valid and decrement discard count; nothing written to instruction FIFO.
REQ-018 SHALL hold id_valid low in the flush cycle; no pop is counted that cycle.
REQ-019 SHALL handle simultaneous push and pop on either FIFO at full or empty without loss; pointers wrap modulo DEPTH, counts log2(DEPTH)+1 bits.
REQ-020 SHALL treat resp_valid with pending FIFO empty and discard zero as ignored (no underflow).
REQ-021 SHALL give one-cycle latency from resp_valid to id_valid when bypass disabled.

Reset
REQ-022 SHALL on resetn low asynchronously clear all pointers, counts, discard count; id_valid=0, id_pc=0, id_inst=0, req_allow=1 after release.
REQ-023 SHALL, on reset mid-transfer, lose all in-flight state; ICache reset concurrently by system.

Configuration
REQ-024 SHALL, with `ICACHE_RESP_BYPASS_EN` defined, forward resp_inst and pending-head PC combinationally to id_* when instruction FIFO empty and discard zero, not writing FIFO if id_ready high (zero latency).
REQ-025 SHALL, without `ICACHE_RESP_BYPASS_EN`, always register responses (REQ-021).

Structure
REQ-026 SHALL place DEPTH default, the 64-bit fetch-entry typedef {pc, inst} and the count-width function in shared package `if_pkg`.
REQ-027 SHALL instantiate a generic sub-module `sync_fifo` twice (pending-tag 32b, instruction 64b) with push/pop/count/full/empty.

Verification
REQ-028 SHALL cover: fires at 0xBFC00000, 0xBFC00004; responses 0x24080001, 0x24090002; id_ready=1 -> id outputs in order with matching PCs, latency 1.
REQ-029 SHALL cover: id_ready=0, DEPTH=4, four fires/responses -> req_allow=0 after 4th fire; fifth request blocked; drain restores req_allow=1.
REQ-030 SHALL cover: two pending, flush -> id_valid=0 next cycle, next two resp_valid dropped, third response (new PC 0x80000180) delivered.
REQ-031 SHALL cover: flush coincident with req_fire and resp_valid -> discard count=2 and response dropped then count 1.
REQ-032 SHALL cover: resetn asserted with 3 entries buffered -> id_valid=0 immediately, req_allow=1 after release.
REQ-033 SHALL cover: `ICACHE_RESP_BYPASS_EN` build, empty buffer, resp_valid with id_ready=1 -> id_valid high same cycle, FIFO count remains 0.

Source files
------------

// File: rtl/icache_resp_buffer_pkg.sv
// Shared definitions for the ICache response buffer: default depth,
// the {pc, inst} fetch entry carried to decode, and the occupancy
// counter width helper used by the FIFOs and the top level.
package if_pkg;

    // Default number of entries in both the pending-tag and instruction queues.
    localparam int IF_DEPTH = 4;

    // One fetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/icache_resp_buffer_if.sv
// Fetch/response/decode signal bundle of the ICache response buffer.
// The slave modport is the buffer's view, the master modport is the
// fetch unit / ICache / decode side that drives it.
interface icache_resp_buffer_if;

    logic        req_fire;
    logic [31:0] req_vaddr;
    logic        req_allow;
    logic        resp_valid;
    logic [31:0] resp_inst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport slave (
        input  req_fire,
        input  req_vaddr,
        output req_allow,
        input  resp_valid,
        input  resp_inst,
        input  flush,
        output id_valid,
        input  id_ready,
        output id_pc,
        output id_inst
    );

    modport master (
        output req_fire,
        output req_vaddr,
        input  req_allow,
        output resp_valid,
        output resp_inst,
        output flush,
        input  id_valid,
        output id_ready,
        input  id_pc,
        input  id_inst
    );

endinterface

// File: rtl/icache_resp_buffer_sync_fifo.sv
// Generic synchronous FIFO (module sync_fifo) with occupancy count.
// Push while full is accepted only together with a pop; pop while empty
// is ignored. i_clear empties the queue synchronously and wins over
// push/pop. Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo
    import if_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          i_clear,
    input  logic                          i_push,
    input  logic [WIDTH-1:0]              i_din,
    input  logic                          i_pop,
    output logic [WIDTH-1:0]              o_dout,
    output logic [cnt_width(DEPTH)-1:0]   o_count,
    output logic                          o_full,
    output logic                          o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        w_do_pop  = i_pop & (r_count != CW'(0));
        w_do_push = i_push & ((r_count != CW'(DEPTH)) | w_do_pop);
    end

    // Storage, pointers and count; clear and reset both empty the queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == CW'(0));

endmodule

// File: rtl/icache_resp_buffer.sv
// ICache response buffer: tags each accepted fetch with its PC, pairs
// in-order ICache responses with those tags and queues {pc, inst} for
// decode. A flush drops everything queued and counts the responses still
// owed by the ICache so they can be discarded when they arrive.
// Optional feature macro: ICACHE_RESP_BYPASS_EN forwards a response
// straight to decode in the same cycle when the instruction queue is empty.
module icache_resp_buffer
    import if_pkg::*;
#(
    parameter int DEPTH = IF_DEPTH
) (
    input  logic                 clk,
    input  logic                 resetn,
    icache_resp_buffer_if.slave  bus
);

    localparam int CW = cnt_width(DEPTH);
    // Discard counter has one extra bit: after a flush new requests may be
    // issued while old responses are still owed, so the total can exceed DEPTH.
    localparam int DW = CW + 1;
    localparam logic [DW-1:0] DISC_MAX = {DW{1'b1}};

    logic [31:0]   w_pend_dout;
    logic [CW-1:0] w_pend_count;
    logic          w_pend_full;
    logic          w_pend_empty;
    logic          w_pend_push;
    logic          w_pend_pop;

    fetch_entry_t  w_inst_din;
    fetch_entry_t  w_inst_dout;
    logic [CW-1:0] w_inst_count;
    logic          w_inst_full;
    logic          w_inst_empty;
    logic          w_inst_push;
    logic          w_inst_pop;

    logic [DW-1:0] r_discard_cnt;
    logic [DW-1:0] w_discard_nxt;
    logic [DW:0]   w_outstanding;
    logic [DW-1:0] w_occupancy;
    logic          w_req_allow;
    logic          w_fire_ok;
    logic          w_disc_zero;
    logic          w_resp_take;
    logic          w_resp_drop;
    logic          w_resp_any;
    logic          w_bypass;
    logic          w_id_valid;
    logic [31:0]   w_id_pc;
    logic [31:0]   w_id_inst;
    logic          w_unused_full;

    // Full flags are implied by req_allow and never needed as conditions.
    assign w_unused_full = w_pend_full | w_inst_full;

    // Admission, response matching and FIFO control.
    always_comb begin
        w_occupancy = {1'b0, w_pend_count} + {1'b0, w_inst_count};
        w_req_allow = (w_occupancy < DW'(DEPTH));
        w_fire_ok   = bus.req_fire & w_req_allow;
        w_disc_zero = (r_discard_cnt == {DW{1'b0}});
        w_resp_take = bus.resp_valid & w_disc_zero & ~w_pend_empty;
        w_resp_drop = bus.resp_valid & ~w_disc_zero;
        w_resp_any  = w_resp_take | w_resp_drop;
`ifdef ICACHE_RESP_BYPASS_EN
        w_bypass    = w_resp_take & w_inst_empty & ~bus.flush;
`else
        w_bypass    = 1'b0;
`endif
        w_pend_push = w_fire_ok & ~bus.flush;
        w_pend_pop  = w_resp_take;
        w_inst_push = w_resp_take & ~bus.flush & ~(w_bypass & bus.id_ready);
        w_inst_pop  = ~w_inst_empty & bus.id_ready & ~bus.flush;
        w_inst_din  = '{pc: w_pend_dout, inst: bus.resp_inst};
    end

    // Next discard count: on flush, every response still owed (old discards,
    // pending tags, a same-cycle fire) minus the one arriving this cycle.
    always_comb begin
        w_outstanding = {1'b0, r_discard_cnt} + {2'b00, w_pend_count}
                      + {{DW{1'b0}}, w_fire_ok} - {{DW{1'b0}}, w_resp_any};
        if (bus.flush) begin
            if (w_outstanding > {1'b0, DISC_MAX}) begin
                w_discard_nxt = DISC_MAX;
            end else begin
                w_discard_nxt = w_outstanding[DW-1:0];
            end
        end else if (w_resp_drop) begin
            w_discard_nxt = r_discard_cnt - DW'(1);
        end else begin
            w_discard_nxt = r_discard_cnt;
        end
    end

    // Discard counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_discard_cnt <= {DW{1'b0}};
        end else begin
            r_discard_cnt <= w_discard_nxt;
        end
    end

    // Decode-side view: queue head, else the bypassed response, else idle.
    always_comb begin
        w_id_valid = 1'b0;
        w_id_pc    = 32'h0000_0000;
        w_id_inst  = 32'h0000_0000;
        if (bus.flush) begin
            w_id_valid = 1'b0;
        end else if (!w_inst_empty) begin
            w_id_valid = 1'b1;
            w_id_pc    = w_inst_dout.pc;
            w_id_inst  = w_inst_dout.inst;
        end else if (w_bypass) begin
            w_id_valid = 1'b1;
            w_id_pc    = w_pend_dout;
            w_id_inst  = bus.resp_inst;
        end else begin
            w_id_valid = 1'b0;
        end
    end

    assign bus.req_allow = w_req_allow;
    assign bus.id_valid  = w_id_valid;
    assign bus.id_pc     = w_id_pc;
    assign bus.id_inst   = w_id_inst;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pend_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (bus.flush),
        .i_push  (w_pend_push),
        .i_din   (bus.req_vaddr),
        .i_pop   (w_pend_pop),
        .o_dout  (w_pend_dout),
        .o_count (w_pend_count),
        .o_full  (w_pend_full),
        .o_empty (w_pend_empty)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_clear (bus.flush),
        .i_push  (w_inst_push),
        .i_din   (w_inst_din),
        .i_pop   (w_inst_pop),
        .o_dout  (w_inst_dout),
        .o_count (w_inst_count),
        .o_full  (w_inst_full),
        .o_empty (w_inst_empty)
    );

endmodule

// File: tb/tb_icache_resp_buffer.sv
// Directed bench for icache_resp_buffer (DEPTH = 4). Inputs change 1ns
// after each rising edge; outputs are sampled there as well.
module tb_icache_resp_buffer;

    logic clk;
    logic resetn;
    int   total;
    int   bad;

    icache_resp_buffer_if bus_if();

    icache_resp_buffer #(.DEPTH(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        total = 0;
        bad = 0;
        resetn = 1'b0;
        bus_if.req_fire   = 1'b0;
        bus_if.req_vaddr  = 32'h0;
        bus_if.resp_valid = 1'b0;
        bus_if.resp_inst  = 32'h0;
        bus_if.flush      = 1'b0;
        bus_if.id_ready   = 1'b0;

        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_id_valid",  64'(bus_if.id_valid),  64'd0);
        check("rst_id_pc",     64'(bus_if.id_pc),     64'd0);
        check("rst_id_inst",   64'(bus_if.id_inst),   64'd0);
        check("rst_req_allow", 64'(bus_if.req_allow), 64'd1);
        resetn = 1'b1;
        tick();

`ifndef ICACHE_RESP_BYPASS_EN
        // ---------------- two fetches, in-order delivery, latency 1
        bus_if.id_ready  = 1'b1;
        bus_if.req_fire  = 1'b1;
        bus_if.req_vaddr = 32'hBFC0_0000;
        tick();
        bus_if.req_vaddr = 32'hBFC0_0004;
        tick();
        bus_if.req_fire  = 1'b0;
        check("t1_allow_2pend", 64'(bus_if.req_allow), 64'd1);
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'h2408_0001;
        #1;
        check("t1_no_same_cycle", 64'(bus_if.id_valid), 64'd0);
        tick();
        bus_if.resp_inst = 32'h2409_0002;
        check("t1_v0",    64'(bus_if.id_valid), 64'd1);
        check("t1_pc0",   64'(bus_if.id_pc),    64'hBFC0_0000);
        check("t1_inst0", 64'(bus_if.id_inst),  64'h2408_0001);
        tick();
        bus_if.resp_valid = 1'b0;
        check("t1_v1",    64'(bus_if.id_valid), 64'd1);
        check("t1_pc1",   64'(bus_if.id_pc),    64'hBFC0_0004);
        check("t1_inst1", 64'(bus_if.id_inst),  64'h2409_0002);
        tick();
        check("t1_drained", 64'(bus_if.id_valid), 64'd0);
        bus_if.id_ready = 1'b0;
`else
        // ---------------- bypass: empty buffer, response forwarded same cycle
        bus_if.id_ready  = 1'b1;
        bus_if.req_fire  = 1'b1;
        bus_if.req_vaddr = 32'hBFC0_0000;
        tick();
        bus_if.req_fire   = 1'b0;
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'h2408_0001;
        #1;
        check("byp_valid", 64'(bus_if.id_valid), 64'd1);
        check("byp_pc",    64'(bus_if.id_pc),    64'hBFC0_0000);
        check("byp_inst",  64'(bus_if.id_inst),  64'h2408_0001);
        tick();
        bus_if.resp_valid = 1'b0;
        check("byp_fifo_cnt", 64'(dut.w_inst_count), 64'd0);
        check("byp_after",    64'(bus_if.id_valid),   64'd0);
        bus_if.id_ready = 1'b0;
`endif

        // ---------------- fill to DEPTH, blocked fifth request, drain
        bus_if.req_fire = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_if.req_vaddr = 32'h0000_1000 + 32'(4 * i);
            tick();
        end
        check("t2_allow_full", 64'(bus_if.req_allow), 64'd0);
        bus_if.req_vaddr = 32'h0000_1010;
        tick();
        bus_if.req_fire = 1'b0;
        check("t2_allow_still0", 64'(bus_if.req_allow), 64'd0);
        bus_if.resp_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_if.resp_inst = 32'hA000_0000 + 32'(i);
            tick();
        end
        // response with nothing pending must be ignored
        bus_if.resp_inst = 32'hDEAD_BEEF;
        tick();
        bus_if.resp_valid = 1'b0;
        check("t2_head_valid", 64'(bus_if.id_valid),  64'd1);
        check("t2_allow_resp", 64'(bus_if.req_allow), 64'd0);
        bus_if.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_drain_pc",    64'(bus_if.id_pc),     64'h1000 + 64'(4 * i));
            check("t2_drain_inst",  64'(bus_if.id_inst),   64'hA000_0000 + 64'(i));
            check("t2_drain_allow", 64'(bus_if.req_allow), (i == 0) ? 64'd0 : 64'd1);
            tick();
        end
        check("t2_empty", 64'(bus_if.id_valid),  64'd0);
        check("t2_allow", 64'(bus_if.req_allow), 64'd1);
        bus_if.id_ready = 1'b0;

        // ---------------- flush with two pending and one queued
        bus_if.req_fire  = 1'b1;
        bus_if.req_vaddr = 32'h0000_2000;
        tick();
        bus_if.req_vaddr  = 32'h0000_2004;
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'h1111_1111;
        tick();
        bus_if.req_vaddr  = 32'h0000_2008;
        bus_if.resp_valid = 1'b0;
        tick();
        bus_if.req_fire = 1'b0;
        check("t3_pre_valid", 64'(bus_if.id_valid), 64'd1);
        check("t3_pre_pc",    64'(bus_if.id_pc),    64'h2000);
        check("t3_pre_inst",  64'(bus_if.id_inst),  64'h1111_1111);
        bus_if.flush    = 1'b1;
        bus_if.id_ready = 1'b1;
        #1;
        check("t3_flush_cycle_valid", 64'(bus_if.id_valid), 64'd0);
        tick();
        bus_if.flush    = 1'b0;
        bus_if.id_ready = 1'b0;
        check("t3_post_valid", 64'(bus_if.id_valid),  64'd0);
        check("t3_discard2",   64'(dut.r_discard_cnt), 64'd2);
        check("t3_allow",      64'(bus_if.req_allow), 64'd1);
        bus_if.req_fire  = 1'b1;
        bus_if.req_vaddr = 32'h8000_0180;
        tick();
        bus_if.req_fire   = 1'b0;
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'hAAAA_0001;
        tick();
        check("t3_drop1_valid", 64'(bus_if.id_valid),   64'd0);
        check("t3_discard1",    64'(dut.r_discard_cnt), 64'd1);
        bus_if.resp_inst = 32'hAAAA_0002;
        tick();
        check("t3_drop2_valid", 64'(bus_if.id_valid),   64'd0);
        check("t3_discard0",    64'(dut.r_discard_cnt), 64'd0);
        bus_if.resp_inst = 32'h3C1A_8000;
        tick();
        bus_if.resp_valid = 1'b0;
        check("t3_new_valid", 64'(bus_if.id_valid), 64'd1);
        check("t3_new_pc",    64'(bus_if.id_pc),    64'h8000_0180);
        check("t3_new_inst",  64'(bus_if.id_inst),  64'h3C1A_8000);
        bus_if.id_ready = 1'b1;
        tick();
        bus_if.id_ready = 1'b0;
        check("t3_consumed", 64'(bus_if.id_valid), 64'd0);

        // ---------------- flush coincident with fire and response
        bus_if.req_fire  = 1'b1;
        bus_if.req_vaddr = 32'h0000_3000;
        tick();
        bus_if.req_vaddr = 32'h0000_3004;
        tick();
        bus_if.flush      = 1'b1;
        bus_if.req_vaddr  = 32'h0000_3008;
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'h5555_0000;
        tick();
        bus_if.flush      = 1'b0;
        bus_if.req_fire   = 1'b0;
        bus_if.resp_valid = 1'b0;
        check("t4_discard2", 64'(dut.r_discard_cnt), 64'd2);
        check("t4_valid0",   64'(bus_if.id_valid),   64'd0);
        check("t4_allow",    64'(bus_if.req_allow),  64'd1);
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'h5555_0001;
        tick();
        check("t4_discard1", 64'(dut.r_discard_cnt), 64'd1);
        check("t4_dropped",  64'(bus_if.id_valid),   64'd0);
        bus_if.resp_inst = 32'h5555_0002;
        tick();
        bus_if.resp_valid = 1'b0;
        check("t4_discard0", 64'(dut.r_discard_cnt), 64'd0);
        check("t4_dropped2", 64'(bus_if.id_valid),   64'd0);

        // ---------------- reset with three entries buffered
        bus_if.req_fire  = 1'b1;
        bus_if.req_vaddr = 32'h0000_4000;
        tick();
        bus_if.req_vaddr  = 32'h0000_4004;
        bus_if.resp_valid = 1'b1;
        bus_if.resp_inst  = 32'h7777_0000;
        tick();
        bus_if.req_vaddr = 32'h0000_4008;
        bus_if.resp_inst = 32'h7777_0001;
        tick();
        bus_if.req_fire  = 1'b0;
        bus_if.resp_inst = 32'h7777_0002;
        tick();
        bus_if.resp_valid = 1'b0;
        check("t5_buffered_valid", 64'(bus_if.id_valid), 64'd1);
        check("t5_buffered_pc",    64'(bus_if.id_pc),    64'h4000);
        #2;
        resetn = 1'b0;
        #1;
        check("t5_rst_valid", 64'(bus_if.id_valid), 64'd0);
        check("t5_rst_pc",    64'(bus_if.id_pc),    64'd0);
        check("t5_rst_inst",  64'(bus_if.id_inst),  64'd0);
        tick();
        resetn = 1'b1;
        tick();
        check("t5_rel_allow", 64'(bus_if.req_allow), 64'd1);
        check("t5_rel_valid", 64'(bus_if.id_valid),  64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
